// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register stage.
// SKID=1: two entries (main + skid) with a registered in_ready.
// SKID=0: one entry with in_ready derived combinationally from out_ready.
// Also provides saturating stall/bubble counters and a registered occupancy count.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [1:0]        occupancy
);

    logic              main_valid, main_valid_nxt;
    logic              skid_valid, skid_valid_nxt;
    logic [DATA_W-1:0] main_data,  main_data_nxt;
    logic [DATA_W-1:0] skid_data,  skid_data_nxt;
    logic              in_fire, out_fire;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_valid & out_ready;
    assign out_valid = main_valid;
    // Data registers are zeroed whenever they empty; the mask also guarantees
    // the bubble encoding at the port.
    assign out_data  = main_valid ? main_data : '0;

    generate
        if (SKID != 0) begin : g_skid_rdy
            logic rdy_q;
            // Ready is registered: the stage can always take one more while skid is free.
            always_ff @(posedge cpu_clk or posedge cpu_rst) begin
                if (cpu_rst) rdy_q <= 1'b1;
                else         rdy_q <= ~skid_valid_nxt;
            end
            assign in_ready = rdy_q;
        end else begin : g_comb_rdy
            assign in_ready = out_ready | ~main_valid;
        end
    endgenerate

    // Next-state of the entries; flush overrides every transfer.
    always_comb begin
        main_valid_nxt = main_valid;
        main_data_nxt  = main_data;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;
        if (flush) begin
            main_valid_nxt = 1'b0;
            main_data_nxt  = '0;
            skid_valid_nxt = 1'b0;
            skid_data_nxt  = '0;
        end else if (SKID != 0) begin
            if (out_fire) begin
                if (skid_valid) begin
                    // Skid advances into main; a new input refills skid.
                    main_valid_nxt = 1'b1;
                    main_data_nxt  = skid_data;
                    skid_valid_nxt = in_fire;
                    skid_data_nxt  = in_fire ? in_data : '0;
                end else begin
                    main_valid_nxt = in_fire;
                    main_data_nxt  = in_fire ? in_data : '0;
                end
            end else if (in_fire) begin
                if (!main_valid) begin
                    main_valid_nxt = 1'b1;
                    main_data_nxt  = in_data;
                end else begin
                    skid_valid_nxt = 1'b1;
                    skid_data_nxt  = in_data;
                end
            end
        end else begin
            if (in_fire) begin
                main_valid_nxt = 1'b1;
                main_data_nxt  = in_data;
            end else if (out_fire) begin
                main_valid_nxt = 1'b0;
                main_data_nxt  = '0;
            end
        end
    end

    // Entry registers and occupancy.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            occupancy  <= 2'd0;
        end else begin
            main_valid <= main_valid_nxt;
            main_data  <= main_data_nxt;
            skid_valid <= skid_valid_nxt;
            skid_data  <= skid_data_nxt;
            occupancy  <= {1'b0, main_valid_nxt} + {1'b0, skid_valid_nxt};
        end
    end

    // Saturating performance counters; clear wins, flush is ignored.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (main_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (!main_valid && out_ready && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: two SKID=1 stages (CNT_W 16 and 4) on shared stimulus
// plus one SKID=0 stage, with in-order scoreboards on the data paths.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    int          n_err = 0;
    int          n_checks = 0;

    // SKID=1 stimulus, shared by dut1 and dutc
    logic        in_valid, out_ready, flush, cnt_clr;
    logic [63:0] in_data;
    logic        in_ready, out_valid, c_in_ready, c_out_valid;
    logic [63:0] out_data, c_out_data;
    logic [15:0] stall_cnt, bubble_cnt;
    logic [3:0]  c_stall_cnt, c_bubble_cnt;
    logic [1:0]  occupancy, c_occupancy;

    // SKID=0 stimulus
    logic        in_valid0, out_ready0;
    logic [15:0] in_data0;
    logic        in_ready0, out_valid0;
    logic [15:0] out_data0, stall_cnt0, bubble_cnt0;
    logic [1:0]  occupancy0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(64), .SKID(1), .CNT_W(16)) dut1 (
        .cpu_clk(clk), .cpu_rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .flush(flush), .cnt_clr(cnt_clr),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .occupancy(occupancy));

    pipe_stage_reg #(.DATA_W(64), .SKID(1), .CNT_W(4)) dutc (
        .cpu_clk(clk), .cpu_rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_data(c_out_data), .flush(flush), .cnt_clr(cnt_clr),
        .stall_cnt(c_stall_cnt), .bubble_cnt(c_bubble_cnt), .occupancy(c_occupancy));

    pipe_stage_reg #(.DATA_W(16), .SKID(0), .CNT_W(16)) dut0 (
        .cpu_clk(clk), .cpu_rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_data(out_data0), .flush(1'b0), .cnt_clr(1'b0),
        .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0), .occupancy(occupancy0));

    // Scoreboards: push on acceptance, pop and compare on output transfer.
    logic [63:0] sb1[$];
    logic [15:0] sb0[$];

    always @(posedge clk or posedge rst) begin
        logic [63:0] exp;
        if (rst || flush) sb1.delete();
        else begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb1.size() == 0) begin
                    n_err++;
                    $display("FAIL sb1_order: got %h, expected no output", out_data);
                end else begin
                    exp = sb1.pop_front();
                    if (out_data !== exp) begin
                        n_err++;
                        $display("FAIL sb1_order: got %h, expected %h", out_data, exp);
                    end
                end
            end
            if (in_valid && in_ready) sb1.push_back(in_data);
        end
    end

    always @(posedge clk or posedge rst) begin
        logic [15:0] exp;
        if (rst) sb0.delete();
        else begin
            if (out_valid0 && out_ready0) begin
                n_checks++;
                if (sb0.size() == 0) begin
                    n_err++;
                    $display("FAIL sb0_order: got %h, expected no output", out_data0);
                end else begin
                    exp = sb0.pop_front();
                    if (out_data0 !== exp) begin
                        n_err++;
                        $display("FAIL sb0_order: got %h, expected %h", out_data0, exp);
                    end
                end
            end
            if (in_valid0 && in_ready0) sb0.push_back(in_data0);
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_data = '0; out_ready = 1; flush = 0; cnt_clr = 0;
        in_valid0 = 0; in_data0 = '0; out_ready0 = 1;
        #2;
        n_checks++;
        if ({out_valid, out_data, occupancy, stall_cnt, bubble_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outs: got v=%b d=%h occ=%0d st=%0d bu=%0d, expected all 0",
                     out_valid, out_data, occupancy, stall_cnt, bubble_cnt);
        end
        n_checks++;
        if (in_ready !== 1'b1 || in_ready0 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got skid=%b noskid=%b, expected 1 1", in_ready, in_ready0);
        end
        n_checks++;
        if (out_valid0 !== 1'b0 || out_data0 !== '0 || occupancy0 !== 2'd0) begin
            n_err++;
            $display("FAIL reset_noskid: got v=%b d=%h occ=%0d, expected 0 0 0",
                     out_valid0, out_data0, occupancy0);
        end
        @(negedge clk); rst = 1'b0;
        cyc();
    endtask

    task automatic test_stream();
        out_ready = 1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1; in_data = 64'(i);
            cyc();
            n_checks++;
            if (out_valid !== 1 || out_data !== 64'(i) || occupancy !== 2'd1 || in_ready !== 1) begin
                n_err++;
                $display("FAIL stream_%0d: got v=%b d=%h occ=%0d rdy=%b, expected 1 %h 1 1",
                         i, out_valid, out_data, occupancy, in_ready, i);
            end
        end
        in_valid = 0; in_data = '0;
        cyc();
        n_checks++;
        if (out_valid !== 0 || out_data !== '0 || occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL stream_bubble: got v=%b d=%h occ=%0d, expected 0 0 0",
                     out_valid, out_data, occupancy);
        end
    endtask

    task automatic test_skid();
        out_ready = 0; in_valid = 1; in_data = 64'hA;
        cyc();
        in_data = 64'hB;
        cyc();
        in_valid = 0; in_data = '0;
        n_checks++;
        if (occupancy !== 2'd2 || in_ready !== 0 || out_data !== 64'hA || out_valid !== 1) begin
            n_err++;
            $display("FAIL skid_full: got occ=%0d rdy=%b d=%h v=%b, expected 2 0 a 1",
                     occupancy, in_ready, out_data, out_valid);
        end
        cyc();
        n_checks++;
        if (occupancy !== 2'd2 || out_data !== 64'hA) begin
            n_err++;
            $display("FAIL skid_stall_hold: got occ=%0d d=%h, expected 2 a", occupancy, out_data);
        end
        out_ready = 1;
        cyc();
        n_checks++;
        if (out_data !== 64'hB || occupancy !== 2'd1 || in_ready !== 1) begin
            n_err++;
            $display("FAIL skid_drain: got d=%h occ=%0d rdy=%b, expected b 1 1",
                     out_data, occupancy, in_ready);
        end
        cyc();
        n_checks++;
        if (out_valid !== 0 || occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL skid_empty: got v=%b occ=%0d, expected 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1; in_data = 64'h11;
        cyc();
        in_data = 64'h22;
        cyc();
        flush = 1; in_data = 64'hC;
        cyc();
        flush = 0; in_valid = 0; in_data = '0;
        n_checks++;
        if (out_valid !== 0 || out_data !== '0 || occupancy !== 2'd0 || in_ready !== 1) begin
            n_err++;
            $display("FAIL flush_clear: got v=%b d=%h occ=%0d rdy=%b, expected 0 0 0 1",
                     out_valid, out_data, occupancy, in_ready);
        end
        out_ready = 1;
        repeat (3) begin
            cyc();
            n_checks++;
            if (out_valid !== 0) begin
                n_err++;
                $display("FAIL flush_no_emit: got v=%b d=%h, expected v=0", out_valid, out_data);
            end
        end
    endtask

    task automatic test_counters();
        cnt_clr = 1; out_ready = 1;
        cyc();
        cnt_clr = 0;
        n_checks++;
        if (stall_cnt !== 0 || bubble_cnt !== 0 || c_stall_cnt !== 0 || c_bubble_cnt !== 0) begin
            n_err++;
            $display("FAIL cnt_clear: got %0d %0d %0d %0d, expected 0 0 0 0",
                     stall_cnt, bubble_cnt, c_stall_cnt, c_bubble_cnt);
        end
        out_ready = 0; in_valid = 1; in_data = 64'h77;
        cyc();
        in_valid = 0; in_data = '0;
        repeat (20) cyc();
        n_checks++;
        if (stall_cnt !== 16'd20 || c_stall_cnt !== 4'd15 || bubble_cnt !== 0) begin
            n_err++;
            $display("FAIL cnt_stall: got st=%0d st4=%0d bu=%0d, expected 20 15 0",
                     stall_cnt, c_stall_cnt, bubble_cnt);
        end
        cnt_clr = 1;
        cyc();
        cnt_clr = 0;
        n_checks++;
        if (stall_cnt !== 0 || c_stall_cnt !== 0) begin
            n_err++;
            $display("FAIL cnt_clr_override: got st=%0d st4=%0d, expected 0 0", stall_cnt, c_stall_cnt);
        end
        out_ready = 1;
        cyc();
        repeat (3) cyc();
        n_checks++;
        if (bubble_cnt !== 16'd3 || c_bubble_cnt !== 4'd3 || stall_cnt !== 0) begin
            n_err++;
            $display("FAIL cnt_bubble: got bu=%0d bu4=%0d st=%0d, expected 3 3 0",
                     bubble_cnt, c_bubble_cnt, stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        out_ready0 = 1;
        for (int k = 0; k < 6; k++) begin
            in_valid0 = 1; in_data0 = 16'h100 + 16'(k);
            cyc();
            n_checks++;
            if (out_valid0 !== 1 || out_data0 !== 16'h100 + 16'(k) || occupancy0 !== 2'd1 || in_ready0 !== 1) begin
                n_err++;
                $display("FAIL b2b_%0d: got v=%b d=%h occ=%0d rdy=%b, expected 1 %h 1 1",
                         k, out_valid0, out_data0, occupancy0, in_ready0, 16'h100 + 16'(k));
            end
        end
        in_valid0 = 0; in_data0 = '0; out_ready0 = 0;
        #1;
        n_checks++;
        if (in_ready0 !== 0) begin
            n_err++;
            $display("FAIL noskid_stall_ready: got %b, expected 0", in_ready0);
        end
        cyc();
        n_checks++;
        if (out_data0 !== 16'h105 || occupancy0 !== 2'd1) begin
            n_err++;
            $display("FAIL noskid_hold: got d=%h occ=%0d, expected 0105 1", out_data0, occupancy0);
        end
        out_ready0 = 1;
        cyc();
        out_ready0 = 0;
        #1;
        n_checks++;
        if (out_valid0 !== 0 || out_data0 !== '0 || in_ready0 !== 1) begin
            n_err++;
            $display("FAIL noskid_empty: got v=%b d=%h rdy=%b, expected 0 0 1",
                     out_valid0, out_data0, in_ready0);
        end
        out_ready0 = 1;
    endtask

    task automatic test_reset_mid();
        out_ready = 0; in_valid = 1; in_data = 64'h33;
        cyc();
        in_data = 64'h44;
        cyc();
        in_valid = 0; in_data = '0;
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 0 || out_data !== '0 || occupancy !== 2'd0 || in_ready !== 1) begin
            n_err++;
            $display("FAIL async_reset: got v=%b d=%h occ=%0d rdy=%b, expected 0 0 0 1",
                     out_valid, out_data, occupancy, in_ready);
        end
        #1 rst = 1'b0;
        in_valid = 1; in_data = 64'h5; out_ready = 1;
        cyc();
        in_valid = 0; in_data = '0;
        n_checks++;
        if (out_valid !== 1 || out_data !== 64'h5 || occupancy !== 2'd1) begin
            n_err++;
            $display("FAIL post_reset: got v=%b d=%h occ=%0d, expected 1 5 1",
                     out_valid, out_data, occupancy);
        end
        cyc();
        n_checks++;
        if (out_valid !== 0) begin
            n_err++;
            $display("FAIL post_reset_drain: got v=%b, expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_counters();
        test_back_to_back();
        test_reset_mid();
        repeat (2) cyc();
        n_checks++;
        if (sb1.size() != 0 || sb0.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d and %0d queued, expected 0 0", sb1.size(), sb0.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
